// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
// EX-stage HI/LO register unit. Captures MULT products and MTHI/MTLO data.
// It runs DIV/DIVU on a 32-step radix-2 restoring divider and exports HI/LO for MFHI/MFLO.
// While a division is in flight, the unit requests a stall.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   hilo_valid       hilo_op is valid this cycle
//   hilo_op[2:0]     000 none, 001 MULT, 010 MTHI, 011 MTLO, 100 DIV, 101 DIVU
//   mul_hi, mul_lo   ALU product halves (MULT)
//   op_a, op_b       dividend/divisor (DIV/DIVU); op_a is MTHI/MTLO data
//   cancel           exception flush; suppresses an IDLE op, aborts a division
//   Hi_out, Lo_out   HI/LO registers
//   busy             divider not idle
//   stall_req        busy, or a DIV/DIVU being issued this cycle
//   div_done         one-cycle pulse after a division result is written
//   div_zero         last completed division had a zero divisor
module hilo_muldiv_unit #(
  parameter int unsigned DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hilo_valid,
  input  logic [2:0]  hilo_op,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        cancel,
  output logic [31:0] Hi_out,
  output logic [31:0] Lo_out,
  output logic        busy,
  output logic        stall_req,
  output logic        div_done,
  output logic        div_zero
);

  localparam logic [2:0] OpMult = 3'b001;
  localparam logic [2:0] OpMthi = 3'b010;
  localparam logic [2:0] OpMtlo = 3'b011;
  localparam logic [2:0] OpDiv  = 3'b100;
  localparam logic [2:0] OpDivu = 3'b101;
  localparam logic [5:0] LastIter = 6'(DIV_ITERS - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_hi, r_lo;
  logic [31:0] r_rem, r_quo, r_div;
  logic [5:0]  r_cnt;
  logic        r_qsign, r_rsign;
  logic        r_done, r_zero;

  logic        w_is_div, w_accept, w_signed;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_trial;
  logic [31:0] w_quo_fix, w_rem_fix;

  assign w_is_div = (hilo_op == OpDiv) || (hilo_op == OpDivu);
  assign w_signed = (hilo_op == OpDiv);
  assign w_accept = (r_state == StIdle) && hilo_valid && w_is_div && !cancel;

  // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude.
  assign w_abs_a = (w_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
  assign w_abs_b = (w_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

  // Trial subtract on the shifted partial remainder; bit 32 is the borrow.
  assign w_trial = {r_rem, r_quo[31]} - {1'b0, r_div};

  assign w_quo_fix = r_qsign ? (~r_quo + 32'd1) : r_quo;
  assign w_rem_fix = r_rsign ? (~r_rem + 32'd1) : r_rem;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = StCalc;
      StCalc: begin
        if (cancel) w_state_next = StIdle;
        else if (r_cnt == LastIter) w_state_next = StFix;
      end
      StFix:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_qsign <= 1'b0;
      r_rsign <= 1'b0;
      r_done  <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (hilo_valid && !cancel) begin
            case (hilo_op)
              OpMult: begin
                r_hi <= mul_hi;
                r_lo <= mul_lo;
              end
              OpMthi: r_hi <= op_a;
              OpMtlo: r_lo <= op_a;
              OpDiv, OpDivu: begin
                r_quo   <= w_abs_a;
                r_div   <= w_abs_b;
                r_rem   <= '0;
                r_cnt   <= '0;
                r_qsign <= w_signed && (op_a[31] ^ op_b[31]);
                r_rsign <= w_signed && op_a[31];
                r_zero  <= (op_b == 32'd0);
              end
              default: ;
            endcase
          end
        end
        StCalc: begin
          if (!cancel) begin
            if (!w_trial[32]) begin
              r_rem <= w_trial[31:0];
              r_quo <= {r_quo[30:0], 1'b1};
            end else begin
              r_rem <= {r_rem[30:0], r_quo[31]};
              r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 6'd1;
          end
        end
        StFix: begin
          if (!cancel) begin
            r_lo   <= w_quo_fix;
            r_hi   <= w_rem_fix;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Hi_out    = r_hi;
  assign Lo_out    = r_lo;
  assign busy      = (r_state != StIdle);
  assign stall_req = busy || (hilo_valid && w_is_div && !cancel);
  assign div_done  = r_done;
  assign div_zero  = r_zero;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: a vector table applied in order, then
// hand-written sequences for latency, dropped ops, cancel and async reset.
module tb_hilo_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hilo_valid = 1'b0;
  logic [2:0]  hilo_op = 3'b000;
  logic [31:0] mul_hi = '0, mul_lo = '0, op_a = '0, op_b = '0;
  logic        cancel = 1'b0;
  logic [31:0] Hi_out, Lo_out;
  logic        busy, stall_req, div_done, div_zero;

  int n_checks = 0;
  int n_errors = 0;

  hilo_muldiv_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hilo_valid (hilo_valid),
    .hilo_op    (hilo_op),
    .mul_hi     (mul_hi),
    .mul_lo     (mul_lo),
    .op_a       (op_a),
    .op_b       (op_b),
    .cancel     (cancel),
    .Hi_out     (Hi_out),
    .Lo_out     (Lo_out),
    .busy       (busy),
    .stall_req  (stall_req),
    .div_done   (div_done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] mhi, mlo, a, b;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op for a single cycle; for divisions wait (bounded) for div_done.
  task automatic issue(input logic [2:0] op, input logic [31:0] mh, input logic [31:0] ml,
                       input logic [31:0] a, input logic [31:0] b);
    int k;
    hilo_valid = 1'b1;
    hilo_op = op;
    mul_hi = mh;
    mul_lo = ml;
    op_a = a;
    op_b = b;
    step();
    hilo_valid = 1'b0;
    hilo_op = 3'b000;
    if (op == 3'b100 || op == 3'b101) begin
      k = 0;
      while (!div_done && k < 40) begin
        step();
        k++;
      end
      if (!div_done) check("div_done_timeout", 32'(div_done), 32'd1);
    end
  endtask

  initial begin
    int n;
    int pulses;

    vecs[0]  = '{3'b001, 32'h1, 32'h2, 32'h0, 32'h0, 32'h1, 32'h2, 1'b0};
    vecs[1]  = '{3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h2, 1'b0};
    vecs[2]  = '{3'b011, 32'h0, 32'h0, 32'h0BADF00D, 32'h0, 32'hDEADBEEF, 32'h0BADF00D, 1'b0};
    vecs[3]  = '{3'b100, 32'h0, 32'h0, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{3'b101, 32'h0, 32'h0, 32'hFFFFFFFF, 32'd16, 32'hF, 32'h0FFFFFFF, 1'b0};
    vecs[5]  = '{3'b100, 32'h0, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0};
    vecs[6]  = '{3'b101, 32'h0, 32'h0, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{3'b101, 32'h0, 32'h0, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0};
    vecs[8]  = '{3'b100, 32'h0, 32'h0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[9]  = '{3'b100, 32'h0, 32'h0, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
    vecs[10] = '{3'b111, 32'h5, 32'h6, 32'h77, 32'h0, 32'd2, 32'd14, 1'b0};
    vecs[11] = '{3'b100, 32'h0, 32'h0, 32'hFFFFFFEC, 32'hFFFFFFFA, 32'hFFFFFFFE, 32'd3, 1'b0};

    // Reset state
    #12;
    check("rst_hi", Hi_out, 32'h0);
    check("rst_lo", Lo_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(div_done), 32'd0);
    check("rst_zero", 32'(div_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].mhi, vecs[i].mlo, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_hi", i), Hi_out, vecs[i].exp_hi);
      check($sformatf("vec%0d_lo", i), Lo_out, vecs[i].exp_lo);
      check($sformatf("vec%0d_zero", i), 32'(div_zero), 32'(vecs[i].exp_zero));
      if (vecs[i].op != 3'b100 && vecs[i].op != 3'b101)
        check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      step();
    end

    // Latency: DIV 7 / -2, stall in issue cycle, busy for 33 cycles, single done pulse
    hilo_valid = 1'b1;
    hilo_op = 3'b100;
    op_a = 32'd7;
    op_b = 32'hFFFFFFFE;
    #1;
    check("issue_stall", 32'(stall_req), 32'd1);
    check("issue_busy", 32'(busy), 32'd0);
    step();
    hilo_valid = 1'b0;
    hilo_op = 3'b000;
    n = 0;
    pulses = 0;
    while (busy && n < 50) begin
      if (div_done) pulses++;
      if (!stall_req) pulses += 100;
      n++;
      step();
    end
    check("busy_cycles", 32'(n), 32'd33);
    check("done_at_end", 32'(div_done), 32'd1);
    check("lat_lo", Lo_out, 32'hFFFFFFFD);
    check("lat_hi", Hi_out, 32'h1);
    step();
    check("done_one_pulse", 32'(div_done), 32'd0);
    check("no_early_done_or_stall_gap", 32'(pulses), 32'd0);

    // MTHI while busy is dropped
    hilo_valid = 1'b1;
    hilo_op = 3'b101;
    op_a = 32'd9;
    op_b = 32'd3;
    step();
    hilo_op = 3'b010;
    op_a = 32'hAAAA5555;
    step();
    hilo_valid = 1'b0;
    hilo_op = 3'b000;
    n = 0;
    while (!div_done && n < 40) begin
      step();
      n++;
    end
    check("drop_done_seen", 32'(div_done), 32'd1);
    check("drop_hi", Hi_out, 32'h0);
    check("drop_lo", Lo_out, 32'd3);
    step();

    // Cancel in IDLE suppresses the op and the stall
    issue(3'b010, 32'h0, 32'h0, 32'h11111111, 32'h0);
    issue(3'b011, 32'h0, 32'h0, 32'h22222222, 32'h0);
    hilo_valid = 1'b1;
    hilo_op = 3'b010;
    op_a = 32'h99999999;
    cancel = 1'b1;
    step();
    check("idle_cancel_hi", Hi_out, 32'h11111111);
    hilo_op = 3'b100;
    op_a = 32'd100;
    op_b = 32'd7;
    #1;
    check("idle_cancel_stall", 32'(stall_req), 32'd0);
    step();
    check("idle_cancel_busy", 32'(busy), 32'd0);

    // Cancel at CALC cycle 10
    cancel = 1'b0;
    step();
    hilo_valid = 1'b0;
    hilo_op = 3'b000;
    for (int i = 1; i < 10; i++) step();
    check("pre_cancel_busy", 32'(busy), 32'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_done) pulses++;
      step();
    end
    check("cancel_no_done", 32'(pulses), 32'd0);
    check("cancel_hi", Hi_out, 32'h11111111);
    check("cancel_lo", Lo_out, 32'h22222222);

    // Async reset mid-CALC
    hilo_valid = 1'b1;
    hilo_op = 3'b100;
    op_a = 32'd1000;
    op_b = 32'd3;
    step();
    hilo_valid = 1'b0;
    hilo_op = 3'b000;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_hi", Hi_out, 32'h0);
    check("arst_lo", Lo_out, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_stall", 32'(stall_req), 32'd0);
    check("arst_done", 32'(div_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(3'b011, 32'h0, 32'h0, 32'h1234, 32'h0);
    check("post_rst_lo", Lo_out, 32'h1234);
    check("post_rst_hi", Hi_out, 32'h0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (div_done || busy) pulses++;
      step();
    end
    check("post_rst_quiet", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
